// File: rtl/io_uart_responder_if.sv
// Byte-wide IO request port between the processor-side requester and the
// UART responder. The requester holds a level request until io_done.
interface io_uart_responder_if;
  logic       io_read_req;
  logic       io_write_req;
  logic [7:0] io_wdata;
  logic       io_ready;
  logic       io_done;
  logic [7:0] io_rdata;

  modport master (
    output io_read_req, io_write_req, io_wdata,
    input  io_ready, io_done, io_rdata
  );

  modport slave (
    input  io_read_req, io_write_req, io_wdata,
    output io_ready, io_done, io_rdata
  );
endinterface

// File: rtl/io_uart_responder.sv
// Responder for the processor IO request port. Received UART bytes wait in
// an RX FIFO until read; written bytes wait in a TX FIFO until the UART
// transmitter takes them. A RELEASE state makes sure a held request is
// serviced only once.
module io_uart_responder #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic               CLK,
  input  logic               RSTN,
  io_uart_responder_if.slave io,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [3:0]         err
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0]   RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW-1:0] RX_PTR_INC  = RX_AW'(1);
  localparam logic [TX_AW-1:0] TX_PTR_INC  = TX_AW'(1);
  localparam logic [RX_AW:0]   RX_CNT_INC  = (RX_AW+1)'(1);
  localparam logic [TX_AW:0]   TX_CNT_INC  = (TX_AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WAIT, S_WR_WAIT, S_DONE, S_RELEASE
  } state_t;

  state_t state_q, state_d;

  logic       io_ready_q, io_done_q;
  logic [7:0] io_rdata_q, io_rdata_d;
  logic [1:0] err_q, err_d;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RX_AW:0]   rx_cnt_q;
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TX_AW:0]   tx_cnt_q;

  logic rx_empty, rx_full, rx_push, rx_pop, rx_ovf;
  logic tx_empty, tx_full, tx_push, tx_pop, tx_space;
  logic conflict;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
  // A full RX FIFO still accepts a byte when the head leaves the same cycle.
  assign rx_push  = rx_valid && (!rx_full || rx_pop);
  assign rx_ovf   = rx_valid && rx_full && !rx_pop;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
  assign tx_pop   = !tx_empty && tx_ready;
  assign tx_space = !tx_full || tx_pop;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_ptr_q];

  assign io.io_ready = io_ready_q;
  assign io.io_done  = io_done_q;
  assign io.io_rdata = io_rdata_q;
  assign err         = {2'b00, err_q};

  // Next-state and FIFO strobes; IDLE services a request in its own cycle.
  always_comb begin
    state_d  = state_q;
    rx_pop   = 1'b0;
    tx_push  = 1'b0;
    conflict = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io.io_write_req) begin
          conflict = io.io_read_req;
          if (tx_space) begin
            tx_push = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WR_WAIT;
          end
        end else if (io.io_read_req) begin
          if (!rx_empty) begin
            rx_pop  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (!rx_empty) begin
          rx_pop  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WR_WAIT: begin
        if (tx_space) begin
          tx_push = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: if (!io.io_read_req && !io.io_write_req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Read data and sticky error next values.
  always_comb begin
    io_rdata_d = rx_pop ? rx_mem_q[rx_rd_ptr_q] : io_rdata_q;
    err_d      = err_q | {conflict, rx_ovf};
  end

  // Control state, output registers and FIFO pointers/counts.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      io_ready_q  <= 1'b0;
      io_done_q   <= 1'b0;
      io_rdata_q  <= 8'h00;
      err_q       <= 2'b00;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      io_ready_q <= (state_d == S_IDLE);
      io_done_q  <= (state_d == S_DONE);
      io_rdata_q <= io_rdata_d;
      err_q      <= err_d;
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RX_PTR_INC;
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RX_PTR_INC;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + RX_CNT_INC;
        2'b01:   rx_cnt_q <= rx_cnt_q - RX_CNT_INC;
        default: rx_cnt_q <= rx_cnt_q;
      endcase
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TX_PTR_INC;
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TX_PTR_INC;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + TX_CNT_INC;
        2'b01:   tx_cnt_q <= tx_cnt_q - TX_CNT_INC;
        default: tx_cnt_q <= tx_cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_data;
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= io.io_wdata;
  end

endmodule

// File: tb/tb_io_uart_responder.sv
// Bench for io_uart_responder: reference RX FIFO model and TX expectation
// queue, with a monitor comparing every TX handshake against the queue head.
module tb_io_uart_responder;
  logic       CLK = 1'b0;
  logic       RSTN;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [3:0] err;

  io_uart_responder_if ifc ();

  io_uart_responder #(.RX_DEPTH(16), .TX_DEPTH(16)) dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .io       (ifc),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [7:0] rx_model [$];
  logic [7:0] tx_exp [$];
  logic ovf_exp  = 1'b0;
  logic conf_exp = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // TX scoreboard: each accepted byte must match the oldest written byte.
  always @(negedge CLK) begin
    if (RSTN === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_exp.size() == 0) chk_eq("tx_unexpected", tx_data, 32'h100);
      else chk_eq("tx_data", tx_data, tx_exp.pop_front());
    end
  end

  task automatic rx_push(input logic [7:0] b);
    @(posedge CLK); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    if (rx_model.size() < 16) rx_model.push_back(b);
    else ovf_exp = 1'b1;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ifc.io_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (ifc.io_ready !== 1'b1) chk_eq("ready_timeout", ifc.io_ready, 1);
  endtask

  task automatic wait_done(input int limit, output int edges);
    edges = 0;
    do begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
    end while (ifc.io_done !== 1'b1 && edges < limit);
    if (ifc.io_done !== 1'b1) chk_eq("done_timeout", ifc.io_done, 1);
  endtask

  task automatic check_rdata(input string tag);
    if (rx_model.size() == 0) chk_eq({tag, "_model"}, rx_model.size(), 1);
    else chk_eq({tag, "_rdata"}, ifc.io_rdata, rx_model.pop_front());
  endtask

  task automatic drop_and_check(input string tag);
    @(posedge CLK); #1;
    ifc.io_read_req  = 1'b0;
    ifc.io_write_req = 1'b0;
    @(negedge CLK);
    chk_eq({tag, "_pulse"}, ifc.io_done, 0);
  endtask

  task automatic do_read(input string tag);
    int lat;
    wait_ready();
    @(posedge CLK); #1;
    ifc.io_read_req = 1'b1;
    wait_done(40, lat);
    chk_eq({tag, "_lat"}, lat, 1);
    check_rdata(tag);
    chk_eq({tag, "_rdy"}, ifc.io_ready, 0);
    drop_and_check(tag);
  endtask

  task automatic do_write(input logic [7:0] b, input string tag);
    int lat;
    wait_ready();
    @(posedge CLK); #1;
    ifc.io_write_req = 1'b1;
    ifc.io_wdata     = b;
    tx_exp.push_back(b);
    wait_done(40, lat);
    chk_eq({tag, "_lat"}, lat, 1);
    drop_and_check(tag);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (tx_valid === 1'b1 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    chk_eq({tag, "_left"}, tx_exp.size(), 0);
    chk_eq({tag, "_valid"}, tx_valid, 0);
  endtask

  initial begin
    int lat;
    int dones;
    RSTN             = 1'b0;
    ifc.io_read_req  = 1'b1;
    ifc.io_write_req = 1'b1;
    ifc.io_wdata     = 8'hEE;
    rx_valid         = 1'b0;
    rx_data          = 8'h00;
    tx_ready         = 1'b1;

    // Reset held with both requests asserted.
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      chk_eq("rst_ready", ifc.io_ready, 0);
      chk_eq("rst_done", ifc.io_done, 0);
      chk_eq("rst_rdata", ifc.io_rdata, 0);
      chk_eq("rst_txvalid", tx_valid, 0);
      chk_eq("rst_txdata", tx_data, 0);
      chk_eq("rst_err", err, 0);
    end
    ifc.io_read_req  = 1'b0;
    ifc.io_write_req = 1'b0;
    RSTN             = 1'b1;
    chk_eq("rdy_before_edge", ifc.io_ready, 0);
    @(negedge CLK);
    chk_eq("rdy_first_cycle", ifc.io_ready, 1);

    // Buffered reads.
    rx_push(8'h41);
    rx_push(8'h42);
    do_read("rd1");
    do_read("rd2");

    // Blocking read: data arrives while the read waits.
    wait_ready();
    @(posedge CLK); #1;
    ifc.io_read_req = 1'b1;
    dones = 0;
    repeat (10) begin
      @(negedge CLK);
      if (ifc.io_done === 1'b1) dones++;
    end
    chk_eq("blk_nodone", dones, 0);
    chk_eq("blk_busy", ifc.io_ready, 0);
    @(posedge CLK); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    rx_model.push_back(8'h5A);
    @(posedge CLK); #1;
    rx_valid = 1'b0;
    @(negedge CLK);
    chk_eq("blk_early", ifc.io_done, 0);
    wait_done(20, lat);
    chk_eq("blk_lat", lat + 1, 2);
    check_rdata("blk");
    drop_and_check("blk");

    // TX backpressure: 16 writes fill the FIFO, the 17th must wait.
    @(posedge CLK); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) do_write(8'(i), "wr");
    wait_ready();
    @(posedge CLK); #1;
    ifc.io_write_req = 1'b1;
    ifc.io_wdata     = 8'h10;
    tx_exp.push_back(8'h10);
    dones = 0;
    repeat (4) begin
      @(negedge CLK);
      if (ifc.io_done === 1'b1) dones++;
    end
    chk_eq("wr17_blocked", dones, 0);
    chk_eq("wr17_busy", ifc.io_ready, 0);
    chk_eq("wr17_head", tx_data, 8'h00);
    @(posedge CLK); #1;
    tx_ready = 1'b1;
    wait_done(10, lat);
    chk_eq("wr17_lat", lat, 1);
    drop_and_check("wr17");
    wait_drain("txbp");

    // RX overflow: 17 strobes, the last byte is dropped.
    for (int i = 0; i < 17; i++) rx_push(8'(i));
    @(negedge CLK);
    chk_eq("ovf_err", err, {2'b00, conf_exp, ovf_exp});
    for (int i = 0; i < 16; i++) do_read("ovf_rd");
    wait_ready();
    @(posedge CLK); #1;
    ifc.io_read_req = 1'b1;
    dones = 0;
    repeat (3) begin
      @(negedge CLK);
      if (ifc.io_done === 1'b1) dones++;
    end
    chk_eq("ovf_empty", dones, 0);
    rx_push(8'h99);
    wait_done(10, lat);
    chk_eq("ovf_tail_lat", lat, 1);
    check_rdata("ovf_tail");
    drop_and_check("ovf_tail");

    // Conflicting requests held for 5 cycles.
    rx_push(8'h77);
    @(posedge CLK); #1;
    tx_ready = 1'b0;
    wait_ready();
    @(posedge CLK); #1;
    ifc.io_read_req  = 1'b1;
    ifc.io_write_req = 1'b1;
    ifc.io_wdata     = 8'h33;
    tx_exp.push_back(8'h33);
    conf_exp = 1'b1;
    dones = 0;
    repeat (5) begin
      @(negedge CLK);
      if (ifc.io_done === 1'b1) begin
        dones++;
        chk_eq("conf_txvalid", tx_valid, 1);
        chk_eq("conf_txdata", tx_data, 8'h33);
      end
    end
    chk_eq("conf_dones", dones, 1);
    chk_eq("conf_err", err, {2'b00, conf_exp, ovf_exp});
    @(posedge CLK); #1;
    ifc.io_read_req  = 1'b0;
    ifc.io_write_req = 1'b0;
    tx_ready         = 1'b1;
    do_read("conf_rd");
    wait_drain("conf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/io_uart_responder.md
# io_uart_responder

Responder end of the processor's byte-wide IO request port: it answers `io_read_req`/`io_write_req` from the controller and bootloader with `io_ready`/`io_done`, and sources or sinks the bytes through buffered UART-side byte streams. Incoming serial bytes are queued in an RX FIFO until a read is requested. Written bytes are queued in a TX FIFO and drained to the UART transmitter. It sits between the processor's IO pins and the UART RX/TX cores.

## Interface
- `RX_DEPTH`, 16, RX FIFO entries; power of two, ≥2.
- `TX_DEPTH`, 16, TX FIFO entries; power of two, ≥2.

- `CLK`  in  1  system clock; all logic on the rising edge.
- `RSTN`  in  1  reset; synchronous, active-low.
- `io_read_req`  in  1  read request, level; held by the requester until `io_done`.
- `io_write_req`  in  1  write request, level; held until `io_done`.
- `io_wdata`  in  8  write byte; valid while `io_write_req` is high.
- `io_ready`  out  1  responder idle and able to accept a request.
- `io_done`  out  1  one-cycle completion pulse.
- `io_rdata`  out  8  read byte; valid in the `io_done` cycle and held until the next read completes.
- `rx_valid`  in  1  one-cycle strobe from the UART receiver.
- `rx_data`  in  8  received byte; valid with `rx_valid`.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_data`  out  8  TX FIFO head.
- `tx_ready`  in  1  UART transmitter accepts `tx_data` this cycle.
- `err`  out  4  sticky errors. [0] RX overflow. [1] simultaneous read and write request. [3:2] tied to 0.

## Operation
- **FSM states:** IDLE, RD_WAIT, WR_WAIT, DONE, RELEASE.
- **IDLE:** `io_ready`=1.
  - `io_write_req` → WR_WAIT logic is applied this same cycle.
  - `io_read_req` only → RD_WAIT logic is applied this same cycle.
  - Both requests high → the write is serviced and `err[1]` is set.
- **RD_WAIT / IDLE-read:** if the RX FIFO is non-empty, pop the head into `io_rdata` and go to DONE. Otherwise stay in RD_WAIT with no timeout.
- **WR_WAIT / IDLE-write:** if the TX FIFO is not full (a pop in the same cycle counts as not full), push `io_wdata` and go to DONE. Otherwise stay in WR_WAIT.
- **DONE:** `io_done`=1 for exactly this cycle. Next state is RELEASE.
- **RELEASE:** wait until both requests are low, then go to IDLE. This prevents a held request from being serviced twice.
- **RX FIFO:**
  - Push on `rx_valid`.
  - Full with no pop in the same cycle → byte dropped, `err[0]` set.
  - Full with a simultaneous pop → push accepted, count unchanged.
  - A pop requires non-empty at the sampling edge. A byte pushed at edge N is poppable at edge N+1.
- **TX FIFO:**
  - `tx_valid` = !empty. Pop on `tx_valid && tx_ready`.
  - Push and pop in the same cycle are both honoured.
- **Pointers:** binary, wrap modulo depth. Counts are log2(depth)+1 bits wide.
- **Request sampling:** requests are not sampled in DONE or RELEASE, except the low-check in RELEASE.
- **`err` bits:** sticky until reset.

## Timing
- **Reset values:** `io_ready`=0, `io_done`=0, `io_rdata`=0, `tx_valid`=0, `tx_data`=0, `err`=0. Both FIFOs are flushed and the state is IDLE.
- **`io_ready` after reset:** registered; it first reads 1 in the cycle after the first edge with RSTN high.
- **Reset mid-transaction:** applied at the next edge. Any pending request is abandoned with no `io_done`. Queued bytes are lost.
- **Read latency, data available:** request seen at edge N (IDLE). `io_done`/`io_rdata` valid in cycle N+1, and `io_ready` is 0 from N+1.
- **Read latency, FIFO empty:** an `rx_valid` at edge M gives `io_done` in cycle M+2.
- **Write latency, space available:** `io_done` in cycle N+1. The byte appears on `tx_data` (if the FIFO was empty) in cycle N+1.
- **Minimum spacing:** if the requester drops its request in the `io_done` cycle, the next accepted request is at edge N+3 (RELEASE at N+2 → IDLE).
- **Output registers:** `io_done`, `io_ready` and `io_rdata` are registered. `tx_valid`/`tx_data` are decoded from FIFO state registers.

## Test plan
- **Reset:** hold RSTN=0 for 3 cycles with requests high → all outputs 0 and no `io_done`. After release, `io_ready`=1 on cycle 1.
- **Buffered read:** push 0x41 and 0x42 via `rx_valid`, then two reads, each dropping the request after `io_done` → `io_rdata`=0x41 then 0x42. Each `io_done` is 1 cycle after request sampling.
- **Blocking read:** read with the RX FIFO empty, then after 10 cycles pulse `rx_valid` with 0x5A → `io_done` exactly 2 cycles after the strobe, `io_rdata`=0x5A.
- **TX backpressure:** `tx_ready`=0, do 17 writes of 0x00..0x10. The 17th write waits in WR_WAIT. Raise `tx_ready` → 17th `io_done` one cycle later, and `tx_data` drains 0x00..0x10 in order.
- **RX overflow:** 17 `rx_valid` strobes with no reads → `err[0]`=1. A read then returns the first byte, and 16 reads return bytes 0..15 (byte 16 dropped).
- **Conflict and held request:** assert both requests with `io_wdata`=0x33 and hold for 5 cycles → exactly one `io_done`, 0x33 queued to TX, `err[1]`=1, RX FIFO untouched.
